// File: rtl/lut_host_port.sv
// lut_host_port
// -------------
// Host-side configuration port for the cell-forwarding lookup table.
// Byte-wide CPU accesses are assembled into whole table entries in a
// staging buffer. A write to the last byte lane commits the entry to the
// table. A read of lane 0 fetches an entry into a snapshot register, and
// reads of the other lanes are then served from that snapshot, so a
// multi-byte read sees one coherent entry. Table access always yields to
// the forwarding datapath while it holds lut_busy.
//
// Ports
//   clk        sole clock, rising edge
//   rst_n      synchronous active-low reset
//   cpu_sel    access select, held by the host until cpu_rdy
//   cpu_wr     write strobe (qualified by cpu_sel)
//   cpu_rd     read strobe (qualified by cpu_sel)
//   cpu_addr   [Asize+1:2] entry index, [1:0] byte lane
//   cpu_wdata  write byte
//   cpu_rdata  registered read byte, held until the next read ack
//   cpu_rdy    one-cycle access acknowledge
//   lut_busy   forwarding datapath owns the table this cycle
//   lut_we     one-cycle table write strobe
//   lut_re     one-cycle table read strobe
//   lut_addr   table index for lut_we / lut_re
//   lut_wdata  entry to write
//   lut_rdata  table read data, valid the cycle after lut_re
module lut_host_port #(
  parameter int Asize  = 8,
  parameter int EntryW = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_sel,
  input  logic              cpu_wr,
  input  logic              cpu_rd,
  input  logic [Asize+1:0]  cpu_addr,
  input  logic [7:0]        cpu_wdata,
  output logic [7:0]        cpu_rdata,
  output logic              cpu_rdy,
  input  logic              lut_busy,
  output logic              lut_we,
  output logic              lut_re,
  output logic [Asize-1:0]  lut_addr,
  output logic [EntryW-1:0] lut_wdata,
  input  logic [EntryW-1:0] lut_rdata
);

  localparam int NB = (EntryW + 7) / 8;
  localparam int SW = NB * 8;
  localparam logic [2:0] LastLane = 3'(NB - 1);
  localparam logic [2:0] NumLanes = 3'(NB);

  typedef enum logic [2:0] {
    IDLE,
    WCOMMIT,
    RREQ,
    RDATA,
    ACK,
    RELEASE
  } state_t;

  state_t          state;
  logic [SW-1:0]   staging;
  logic [SW-1:0]   snapshot;
  logic [2:0]      lane;
  logic [Asize-1:0] index;
  logic            take;
  logic [SW-1:0]   rdata_ext;

  assign lane      = {1'b0, cpu_addr[1:0]};
  assign index     = cpu_addr[Asize+1:2];
  assign take      = cpu_sel && (cpu_wr ^ cpu_rd);
  assign rdata_ext = SW'(lut_rdata);

  // The table strobes must react to lut_busy in the very cycle they would
  // fire, so they are decoded from the registered state rather than being
  // registered themselves. Gating with rst_n keeps a strobe from escaping
  // in the cycle a reset aborts a pending commit or fetch.
  assign lut_we    = rst_n && (state == WCOMMIT) && !lut_busy;
  assign lut_re    = rst_n && (state == RREQ) && !lut_busy;
  assign lut_wdata = staging[EntryW-1:0];

  // Access sequencer. cpu_rdy is raised on the transition into ACK and
  // defaults low every other cycle, so it is high for exactly the one
  // cycle spent in ACK. RELEASE waits for the host to drop cpu_sel so a
  // held strobe can never start a second access.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      cpu_rdy   <= 1'b0;
      cpu_rdata <= 8'h00;
      lut_addr  <= '0;
      staging   <= '0;
      snapshot  <= '0;
    end else begin
      cpu_rdy <= 1'b0;
      case (state)
        IDLE: begin
          if (take) begin
            if (cpu_wr) begin
              if (lane < NumLanes) begin
                for (int i = 0; i < NB; i++) begin
                  if (lane == 3'(i)) staging[i*8 +: 8] <= cpu_wdata;
                end
              end
              if (lane == LastLane) begin
                lut_addr <= index;
                state    <= WCOMMIT;
              end else begin
                cpu_rdy <= 1'b1;
                state   <= ACK;
              end
            end else begin
              if (lane == 3'd0) begin
                lut_addr <= index;
                state    <= RREQ;
              end else begin
                // Lanes beyond the entry width read back as zero.
                cpu_rdata <= 8'h00;
                for (int i = 1; i < NB; i++) begin
                  if (lane == 3'(i)) cpu_rdata <= snapshot[i*8 +: 8];
                end
                cpu_rdy <= 1'b1;
                state   <= ACK;
              end
            end
          end
        end

        WCOMMIT: begin
          if (!lut_busy) begin
            cpu_rdy <= 1'b1;
            state   <= ACK;
          end
        end

        RREQ: begin
          if (!lut_busy) state <= RDATA;
        end

        RDATA: begin
          snapshot  <= rdata_ext;
          cpu_rdata <= rdata_ext[7:0];
          cpu_rdy   <= 1'b1;
          state     <= ACK;
        end

        ACK: begin
          state <= RELEASE;
        end

        RELEASE: begin
          if (!cpu_sel) state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lut_host_port.sv
// tb_lut_host_port
// ----------------
// Self-checking bench for lut_host_port. A driver issues host accesses and
// pushes the expected acknowledges and table strobes into queues, computed
// from a byte-array model of the staging buffer, snapshot and table. A
// monitor pops and compares whenever the DUT shows cpu_rdy, lut_we or
// lut_re. The table itself is emulated by a simple memory.
module tb_lut_host_port;

  localparam int Asize  = 8;
  localparam int EntryW = 16;
  localparam int NB     = (EntryW + 7) / 8;
  localparam longint Mask = (longint'(1) << EntryW) - 1;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              cpu_sel;
  logic              cpu_wr;
  logic              cpu_rd;
  logic [Asize+1:0]  cpu_addr;
  logic [7:0]        cpu_wdata;
  logic [7:0]        cpu_rdata;
  logic              cpu_rdy;
  logic              lut_busy;
  logic              lut_we;
  logic              lut_re;
  logic [Asize-1:0]  lut_addr;
  logic [EntryW-1:0] lut_wdata;
  logic [EntryW-1:0] lut_rdata;

  lut_host_port #(.Asize(Asize), .EntryW(EntryW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cpu_sel   (cpu_sel),
    .cpu_wr    (cpu_wr),
    .cpu_rd    (cpu_rd),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_rdata (cpu_rdata),
    .cpu_rdy   (cpu_rdy),
    .lut_busy  (lut_busy),
    .lut_we    (lut_we),
    .lut_re    (lut_re),
    .lut_addr  (lut_addr),
    .lut_wdata (lut_wdata),
    .lut_rdata (lut_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    int     cyc;
    bit     is_rd;
    int     rdata;
  } ack_t;

  typedef struct {
    int     cyc;
    int     addr;
    longint data;
  } strobe_t;

  ack_t    ack_q[$];
  strobe_t we_q[$];
  strobe_t re_q[$];

  int checks = 0;
  int errors = 0;
  int cycle  = 0;

  // Reference model: bytes of the staging buffer, the snapshot entry and
  // the expected table contents.
  int          stg[NB];
  longint      snap;
  longint      ref_tbl[1 << Asize];
  logic [EntryW-1:0] mem[1 << Asize];

  always @(posedge clk) cycle <= cycle + 1;

  // Table emulation: write on lut_we, read data one cycle after lut_re,
  // garbage otherwise so a mistimed capture shows up.
  always @(posedge clk) begin
    if (lut_we) mem[lut_addr] <= lut_wdata;
    if (lut_re) lut_rdata <= mem[lut_addr];
    else        lut_rdata <= EntryW'($urandom);
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at cycle %0d", name, act, exp, cycle);
    end
  endtask

  // Monitor: compares every acknowledge and table strobe against the
  // head of the matching expectation queue.
  always @(negedge clk) begin
    if (lut_we || lut_re) begin
      checkOutput("strobe_during_busy", lut_busy, 0);
      checkOutput("we_and_re_together", lut_we && lut_re, 0);
    end
    if (lut_we) begin
      if (we_q.size() == 0) checkOutput("unexpected_we", 1, 0);
      else begin
        strobe_t e;
        e = we_q.pop_front();
        checkOutput("we_cycle", cycle, e.cyc);
        checkOutput("we_addr", lut_addr, e.addr);
        checkOutput("we_data", lut_wdata, e.data);
      end
    end
    if (lut_re) begin
      if (re_q.size() == 0) checkOutput("unexpected_re", 1, 0);
      else begin
        strobe_t e;
        e = re_q.pop_front();
        checkOutput("re_cycle", cycle, e.cyc);
        checkOutput("re_addr", lut_addr, e.addr);
      end
    end
    if (rst_n && cpu_rdy) begin
      if (ack_q.size() == 0) checkOutput("unexpected_rdy", 1, 0);
      else begin
        ack_t a;
        a = ack_q.pop_front();
        checkOutput("rdy_cycle", cycle, a.cyc);
        if (a.is_rd) checkOutput("rdata", cpu_rdata, a.rdata);
      end
    end
  end

  // One host access: predicts the response from the model, drives the
  // bus, applies 'busy' cycles of lut_busy after acceptance, then keeps
  // cpu_sel held for 'hold' extra cycles after the acknowledge.
  task automatic applyStimulus(input bit wr, input bit rd, input logic [Asize+1:0] addr,
                               input logic [7:0] data, input int busy, input int hold);
    int     idx;
    int     lane;
    int     t0;
    int     waited;
    int     acks;
    bit     got;
    longint ent;
    @(posedge clk); #1;
    cpu_sel   = 1'b1;
    cpu_wr    = wr;
    cpu_rd    = rd;
    cpu_addr  = addr;
    cpu_wdata = data;
    lut_busy  = 1'b0;
    t0   = cycle;
    idx  = int'(addr[Asize+1:2]);
    lane = int'(addr[1:0]);

    if (wr == rd) begin
      acks = 0;
      for (int c = 1; c <= 3; c++) begin
        @(negedge clk);
        if (cpu_rdy) acks++;
      end
      checkOutput("ignored_access_rdy", acks, 0);
    end else begin
      if (wr) begin
        if (lane < NB) stg[lane] = int'(data);
        if (lane == NB - 1) begin
          ent = 0;
          for (int i = 0; i < NB; i++) ent = ent + (longint'(stg[i]) << (8 * i));
          ent = ent & Mask;
          ref_tbl[idx] = ent;
          we_q.push_back('{cyc: t0 + 1 + busy, addr: idx, data: ent});
          ack_q.push_back('{cyc: t0 + 2 + busy, is_rd: 1'b0, rdata: 0});
        end else begin
          ack_q.push_back('{cyc: t0 + 1, is_rd: 1'b0, rdata: 0});
        end
      end else begin
        if (lane == 0) begin
          snap = ref_tbl[idx];
          re_q.push_back('{cyc: t0 + 1 + busy, addr: idx, data: 0});
          ack_q.push_back('{cyc: t0 + 3 + busy, is_rd: 1'b1, rdata: int'(snap & 'hFF)});
        end else if (lane < NB) begin
          ack_q.push_back('{cyc: t0 + 1, is_rd: 1'b1, rdata: int'((snap >> (8 * lane)) & 'hFF)});
        end else begin
          ack_q.push_back('{cyc: t0 + 1, is_rd: 1'b1, rdata: 0});
        end
      end

      waited = 0;
      got    = 1'b0;
      while (!got && waited < 60) begin
        @(posedge clk); #1;
        waited++;
        lut_busy = (waited <= busy);
        @(negedge clk);
        if (cpu_rdy) got = 1'b1;
      end
      lut_busy = 1'b0;
      if (!got) checkOutput("rdy_timeout", 0, 1);
      repeat (hold) begin
        @(posedge clk); #1;
      end
    end
    @(posedge clk); #1;
    cpu_sel  = 1'b0;
    cpu_wr   = 1'b0;
    cpu_rd   = 1'b0;
    lut_busy = 1'b0;
  endtask

  function automatic logic [Asize+1:0] mkAddr(input int idx, input int lane);
    return {Asize'(idx), 2'(lane)};
  endfunction

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog expired at cycle %0d", cycle);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int idx;
    int lane;
    int op;
    rst_n     = 1'b0;
    cpu_sel   = 1'b0;
    cpu_wr    = 1'b0;
    cpu_rd    = 1'b0;
    cpu_addr  = '0;
    cpu_wdata = '0;
    lut_busy  = 1'b0;
    for (int i = 0; i < NB; i++) stg[i] = 0;
    snap = 0;
    for (int i = 0; i < (1 << Asize); i++) begin
      ref_tbl[i] = longint'($urandom) & Mask;
      mem[i]     = EntryW'(ref_tbl[i]);
    end

    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_rdy", cpu_rdy, 0);
    checkOutput("reset_rdata", cpu_rdata, 0);
    checkOutput("reset_we", lut_we, 0);
    checkOutput("reset_re", lut_re, 0);
    checkOutput("reset_addr", lut_addr, 0);
    checkOutput("reset_wdata", lut_wdata, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    $display("[TB] directed accesses");
    applyStimulus(0, 1, 10'h015, 8'h00, 0, 0);
    applyStimulus(1, 0, 10'h014, 8'hA5, 0, 0);
    applyStimulus(1, 0, 10'h015, 8'h3C, 0, 0);
    applyStimulus(0, 1, 10'h014, 8'h00, 0, 0);
    applyStimulus(0, 1, 10'h015, 8'h00, 0, 0);
    applyStimulus(1, 0, 10'h014, 8'h11, 0, 0);
    applyStimulus(1, 0, 10'h015, 8'h22, 4, 0);
    applyStimulus(0, 1, 10'h014, 8'h00, 3, 0);
    applyStimulus(1, 0, 10'h016, 8'hEE, 0, 0);
    applyStimulus(0, 1, 10'h016, 8'h00, 0, 0);
    applyStimulus(1, 0, 10'h025, 8'h33, 0, 0);
    applyStimulus(1, 0, 10'h014, 8'h44, 0, 3);
    applyStimulus(1, 0, 10'h015, 8'h55, 0, 3);
    applyStimulus(1, 1, 10'h014, 8'h66, 0, 0);

    $display("[TB] reset during a stalled commit");
    @(posedge clk); #1;
    cpu_sel   = 1'b1;
    cpu_wr    = 1'b1;
    cpu_addr  = mkAddr(3, NB - 1);
    cpu_wdata = 8'h99;
    lut_busy  = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n   = 1'b0;
    cpu_sel = 1'b0;
    cpu_wr  = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checkOutput("abort_rdy", cpu_rdy, 0);
    checkOutput("abort_rdata", cpu_rdata, 0);
    checkOutput("abort_we", lut_we, 0);
    checkOutput("abort_re", lut_re, 0);
    checkOutput("abort_addr", lut_addr, 0);
    checkOutput("abort_wdata", lut_wdata, 0);
    @(posedge clk); #1;
    rst_n    = 1'b1;
    lut_busy = 1'b0;
    for (int i = 0; i < NB; i++) stg[i] = 0;
    snap = 0;
    applyStimulus(0, 1, mkAddr(9, 1), 8'h00, 0, 0);
    applyStimulus(1, 0, mkAddr(9, NB - 1), 8'h77, 0, 0);
    applyStimulus(0, 1, mkAddr(9, 0), 8'h00, 1, 0);

    $display("[TB] randomized accesses");
    for (int n = 0; n < 250; n++) begin
      idx  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, (1 << Asize) - 1) : $urandom_range(0, 7);
      lane = $urandom_range(0, 3);
      op   = $urandom_range(0, 9);
      if (op == 0)
        applyStimulus(1, 1, mkAddr(idx, lane), 8'($urandom), 0, 0);
      else if (op < 5)
        applyStimulus(1, 0, mkAddr(idx, lane), 8'($urandom), $urandom_range(0, 3), $urandom_range(0, 2));
      else
        applyStimulus(0, 1, mkAddr(idx, lane), 8'h00, $urandom_range(0, 3), $urandom_range(0, 2));
    end

    repeat (4) @(posedge clk);
    @(negedge clk);
    checkOutput("ack_queue_drained", ack_q.size(), 0);
    checkOutput("we_queue_drained", we_q.size(), 0);
    checkOutput("re_queue_drained", re_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
